// File: rtl/crc32.sv
// crc32 - parallel reflected CRC-32 (IEEE 802.3 FCS) engine.
//
// Each clock it folds up to SLICE_LENGTH bytes into the running CRC. Lane 0
// is the first byte on the wire. A cycle with no valid lanes closes the frame,
// and the next non-empty word starts again from INITIAL_CRC.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous active-low reset
//   in_data  : SLICE_LENGTH byte lanes, lane k = in_data[8k+7:8k]
//   in_valid : per-lane qualifier; only the run of 1s from bit 0 is consumed
//   out_crc  : CRC of the current or most recent frame
module crc32 #(
  parameter int          SLICE_LENGTH     = 4,
  parameter logic [31:0] INITIAL_CRC      = 32'hFFFF_FFFF,
  parameter bit          INVERT_OUTPUT    = 1'b1,
  parameter bit          REGISTER_OUTPUT  = 1'b1,
  parameter int          MAX_SLICE_LENGTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*SLICE_LENGTH-1:0] in_data,
  input  logic [SLICE_LENGTH-1:0]   in_valid,
  output logic [31:0]               out_crc
);

  localparam logic [31:0] POLY_REFLECTED = 32'hEDB8_8320;
  localparam logic [31:0] RESET_OUT      = INVERT_OUTPUT ? ~INITIAL_CRC : INITIAL_CRC;

  // Reject slice widths the engine is not built for.
  if ((SLICE_LENGTH < 1) || (SLICE_LENGTH > MAX_SLICE_LENGTH)) begin : g_bad_slice_length
    $error("crc32: SLICE_LENGTH must lie in 1..MAX_SLICE_LENGTH");
  end

  // Advance a reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = (c >> 1) ^ POLY_REFLECTED;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [31:0] crc_reg_r;
  logic        idle_r;
  logic [31:0] seed_s;
  logic [31:0] next_crc_s;
  logic        run_s;
  logic        any_valid_s;
  logic [31:0] crc_out_s;

  // The byte count is a thermometer prefix of in_valid, so a word is
  // non-empty exactly when lane 0 is valid.
  assign any_valid_s = in_valid[0];

  // Fold the leading run of valid lanes into the seed; the first invalid lane
  // stops the run so later lanes (valid or not) are ignored.
  always_comb begin
    seed_s     = crc_reg_r;
    next_crc_s = crc_reg_r;
    run_s      = 1'b1;
    if (idle_r) begin
      seed_s = INITIAL_CRC;
    end else begin
      seed_s = crc_reg_r;
    end
    next_crc_s = seed_s;
    for (int k = 0; k < SLICE_LENGTH; k++) begin
      if (run_s && in_valid[k]) begin
        next_crc_s = crc_byte(next_crc_s, in_data[8*k +: 8]);
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // CRC state and frame-boundary flag; an empty word holds the CRC and marks
  // the next non-empty word as the start of a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_reg_r <= INITIAL_CRC;
      idle_r    <= 1'b1;
    end else if (any_valid_s) begin
      crc_reg_r <= next_crc_s;
      idle_r    <= 1'b0;
    end else begin
      idle_r    <= 1'b1;
    end
  end

  // Optional final complement of the state.
  always_comb begin
    crc_out_s = crc_reg_r;
    if (INVERT_OUTPUT) begin
      crc_out_s = ~crc_reg_r;
    end else begin
      crc_out_s = crc_reg_r;
    end
  end

  if (REGISTER_OUTPUT) begin : g_out_reg
    logic [31:0] out_reg_r;

    // Output pipeline stage, refreshed every cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_reg_r <= RESET_OUT;
      end else begin
        out_reg_r <= crc_out_s;
      end
    end

    assign out_crc = out_reg_r;
  end else begin : g_out_comb
    assign out_crc = crc_out_s;
  end

endmodule

// File: tb/tb_crc32.sv
// tb_crc32 - self-checking bench for crc32. Two instances share the stimulus:
// one with default parameters (complemented output) and one with the final
// complement disabled. Expected FCS values are pushed to a scoreboard queue
// as each frame is driven and popped once the output is due.
module tb_crc32;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [31:0] out_crc;
  logic [31:0] out_crc_raw;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  crc32 dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_crc  (out_crc)
  );

  crc32 #(.INVERT_OUTPUT(1'b0)) dut_raw (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_crc  (out_crc_raw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one word at a falling edge and advance to the next falling edge.
  task automatic put(input logic [31:0] d, input logic [3:0] v);
    in_data  = d;
    in_valid = v;
    @(negedge clk);
  endtask

  // "123456789" as three words, the last one a single-byte partial word.
  task automatic put_check_string(input logic [31:0] last_word, input logic [3:0] last_valid);
    put(32'h3433_3231, 4'hF);
    put(32'h3837_3635, 4'hF);
    exp_q.push_back(32'hCBF4_3926);
    put(last_word, last_valid);
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    in_data  = 32'h0000_0000;
    in_valid = 4'h0;
    @(negedge clk);
    tests_run++;
    if (out_crc !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reset_out: got %08h want %08h", out_crc, 32'h0000_0000);
    end
    tests_run++;
    if (out_crc_raw !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL reset_out_raw: got %08h want %08h", out_crc_raw, 32'hFFFF_FFFF);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_check_string;
    put_check_string(32'h0000_0039, 4'h1);
    put(32'h0000_0000, 4'h0);
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_crc !== exp_v) begin
        tests_failed++;
        $display("FAIL check_string[%0d]: got %08h want %08h", i, out_crc, exp_v);
      end
      tests_run++;
      if (out_crc_raw !== ~exp_v) begin
        tests_failed++;
        $display("FAIL check_string_raw[%0d]: got %08h want %08h", i, out_crc_raw, ~exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_long_stream;
    logic [31:0] words [16];
    logic [3:0]  masks [16];
    words = '{32'h3322_1100, 32'hBBAA_5544, 32'hFFEE_DDCC, 32'h0000_0008,
              32'hA1B2_C3D4, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8765_4321,
              32'hFEDC_BA98, 32'h55AA_33CC, 32'h9F8E_7D6C, 32'h1A2B_3C4D,
              32'hCAFE_BABE, 32'h6789_ABCD, 32'hF0E1_D2C3, 32'h3E5F_7A9B};
    masks = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF,
              4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    exp_q.push_back(32'h713B_28B2);
    for (int i = 0; i < 16; i++) begin
      put(words[i], masks[i]);
    end
    put(32'h0000_0000, 4'h0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (out_crc !== exp_v) begin
      tests_failed++;
      $display("FAIL long_stream: got %08h want %08h", out_crc, exp_v);
    end
    tests_run++;
    if (out_crc_raw !== ~exp_v) begin
      tests_failed++;
      $display("FAIL long_stream_raw: got %08h want %08h", out_crc_raw, ~exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 2; f++) begin
      put_check_string(32'h0000_0039, 4'h1);
      put(32'h0000_0000, 4'h0);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (out_crc !== exp_v) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got %08h want %08h", f, out_crc, exp_v);
      end
      tests_run++;
      if (out_crc_raw !== ~exp_v) begin
        tests_failed++;
        $display("FAIL back_to_back_raw[%0d]: got %08h want %08h", f, out_crc_raw, ~exp_v);
      end
    end
    put(32'h0000_0000, 4'h0);
  endtask

  task automatic test_invalid_lanes;
    logic [31:0] last_words [2];
    logic [3:0]  last_masks [2];
    // Garbage above the valid byte, then a non-thermometer mask whose
    // valid lanes beyond the first gap must be ignored.
    last_words = '{32'hFFFF_FF39, 32'hAABB_CC39};
    last_masks = '{4'h1, 4'hD};
    for (int c = 0; c < 2; c++) begin
      put_check_string(last_words[c], last_masks[c]);
      put(32'hDEAD_BEEF, 4'h0);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (out_crc !== exp_v) begin
        tests_failed++;
        $display("FAIL invalid_lanes[%0d]: got %08h want %08h", c, out_crc, exp_v);
      end
      tests_run++;
      if (out_crc_raw !== ~exp_v) begin
        tests_failed++;
        $display("FAIL invalid_lanes_raw[%0d]: got %08h want %08h", c, out_crc_raw, ~exp_v);
      end
      put(32'h0000_0000, 4'h0);
    end
  endtask

  task automatic test_reset_mid_frame;
    put(32'h3433_3231, 4'hF);
    in_data  = 32'h3837_3635;
    in_valid = 4'hF;
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_crc !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: got %08h want %08h", out_crc, 32'h0000_0000);
    end
    tests_run++;
    if (out_crc_raw !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL reset_mid_frame_raw: got %08h want %08h", out_crc_raw, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    in_valid = 4'h0;
    rst      = 1'b1;
    @(negedge clk);
    put_check_string(32'h0000_0039, 4'h1);
    put(32'h0000_0000, 4'h0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (out_crc !== exp_v) begin
      tests_failed++;
      $display("FAIL after_reset_frame: got %08h want %08h", out_crc, exp_v);
    end
    tests_run++;
    if (out_crc_raw !== ~exp_v) begin
      tests_failed++;
      $display("FAIL after_reset_frame_raw: got %08h want %08h", out_crc_raw, ~exp_v);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_check_string();
    test_long_stream();
    test_back_to_back();
    test_invalid_lanes();
    test_reset_mid_frame();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries want %0d", exp_q.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
